// File: rtl/tomasula_types.sv
// Shared operation encoding for the Tomasulo back end.
package tomasula_types;

   typedef enum logic [1:0] {
      OP_ALU    = 2'd0,
      OP_LD     = 2'd1,
      OP_ST     = 2'd2,
      OP_BRANCH = 2'd3
   } op_t;

endpackage

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, CDB capture by tag, in-order retire
// (LD/ST through a d-cache handshake) and single-cycle squash of a mispredicted path.
module rob_param
   import tomasula_types::*;
#(
   parameter int  DEPTH  = 8,
   parameter int  DATA_W = 32,
   localparam int TAG_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alloc_valid,
   output logic              alloc_ready,
   input  op_t               alloc_op,
   input  logic [4:0]        alloc_rd,
   output logic [TAG_W-1:0]  alloc_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic [DATA_W-1:0] cdb_data,
   input  logic              flush_valid,
   input  logic [TAG_W-1:0]  flush_tag,
   output logic              mem_req,
   output logic              mem_we,
   input  logic              mem_resp,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              commit_valid,
   output op_t               commit_op,
   output logic [4:0]        commit_rd,
   output logic [DATA_W-1:0] commit_data,
   output logic [TAG_W-1:0]  commit_tag,
   output logic [TAG_W-1:0]  head_tag,
   output logic [TAG_W:0]    count,
   output logic              full,
   output logic              empty
);

   typedef enum logic {S_IDLE, S_MEM} state_t;

   state_t              state_q, state_d;
   logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [TAG_W:0]      count_q, count_d;
   logic [DEPTH-1:0]    busy_q, busy_d, done_q, done_d, squash;
   op_t                 op_q   [DEPTH];
   logic [4:0]          rd_q   [DEPTH];
   logic [DATA_W-1:0]   data_q [DEPTH];
   logic                do_alloc, do_retire, cdb_hit, head_ready, head_mem;
   logic [TAG_W-1:0]    span;

   logic                commit_valid_q;
   op_t                 commit_op_q;
   logic [4:0]          commit_rd_q;
   logic [DATA_W-1:0]   commit_data_q;
   logic [TAG_W-1:0]    commit_tag_q;

   assign full        = (count_q == (TAG_W+1)'(DEPTH));
   assign empty       = (count_q == '0);
   assign alloc_ready = rst && !full && !flush_valid;
   assign do_alloc    = alloc_valid && alloc_ready;
   assign cdb_hit     = cdb_valid && busy_q[cdb_tag] && !squash[cdb_tag];
   assign head_ready  = busy_q[head_q] && done_q[head_q];
   assign head_mem    = (op_q[head_q] == OP_LD) || (op_q[head_q] == OP_ST);
   assign mem_req     = (state_q == S_MEM);
   assign mem_we      = mem_req && (op_q[head_q] == OP_ST);

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      do_retire = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (head_ready) begin
               if (head_mem) state_d   = S_MEM;
               else          do_retire = 1'b1;
            end
         end
         S_MEM: begin
            if (mem_resp) begin
               do_retire = 1'b1;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Entry i is younger than the branch when its distance past flush_tag is below
   // the number of entries allocated after the branch.
   assign span = tail_q - flush_tag - 1'b1;

   always_comb begin
      squash = '0;
      for (int i = 0; i < DEPTH; i++)
         squash[i] = flush_valid && (TAG_W'(TAG_W'(i) - flush_tag - 1'b1) < span);
   end

   always_comb begin
      head_d  = head_q + TAG_W'(do_retire);
      tail_d  = tail_q + TAG_W'(do_alloc);
      count_d = count_q + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(do_retire);
      if (flush_valid) begin
         tail_d  = flush_tag + 1'b1;
         count_d = (TAG_W+1)'(TAG_W'(flush_tag - head_d)) + 1'b1;
      end
   end

   always_comb begin
      busy_d = busy_q & ~squash;
      done_d = done_q & ~squash;
      if (cdb_hit) done_d[cdb_tag] = 1'b1;
      if (do_retire) begin
         busy_d[head_q] = 1'b0;
         done_d[head_q] = 1'b0;
      end
      if (do_alloc) begin
         busy_d[tail_q] = 1'b1;
         done_d[tail_q] = 1'b0;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         busy_q         <= '0;
         done_q         <= '0;
         commit_valid_q <= 1'b0;
         commit_op_q    <= OP_ALU;
         commit_rd_q    <= '0;
         commit_data_q  <= '0;
         commit_tag_q   <= '0;
      end else begin
         state_q        <= state_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         commit_valid_q <= do_retire;
         if (do_retire) begin
            commit_op_q   <= op_q[head_q];
            commit_rd_q   <= rd_q[head_q];
            commit_data_q <= (op_q[head_q] == OP_LD) ? mem_rdata : data_q[head_q];
            commit_tag_q  <= head_q;
         end
      end
   end

   // NOTE: payload arrays carry no reset; busy_q/done_q qualify every read of them.
   always_ff @(posedge clk) begin
      if (do_alloc) begin
         op_q[tail_q] <= alloc_op;
         rd_q[tail_q] <= alloc_rd;
      end
      if (cdb_hit) data_q[cdb_tag] <= cdb_data;
   end

   assign alloc_tag    = tail_q;
   assign head_tag     = head_q;
   assign count        = count_q;
   assign commit_valid = commit_valid_q;
   assign commit_op    = commit_op_q;
   assign commit_rd    = commit_rd_q;
   assign commit_data  = commit_data_q;
   assign commit_tag   = commit_tag_q;

   a_flush_names_branch: assert property (@(posedge clk) disable iff (!rst)
      flush_valid |-> (busy_q[flush_tag] && (op_q[flush_tag] == OP_BRANCH)));

endmodule
